// File: rtl/count_compare_pwm_pkg.sv
// counter_pkg: shared defaults for the upstream 8-bit counter and its consumers.
package counter_pkg;
    localparam int CNT_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_CMP_RESET = 8'h80;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
endpackage

// File: rtl/count_compare_pwm_edge_detect.sv
// count_edge_detect: remembers the previous count sample and flags natural wraps and discontinuities.
module count_edge_detect
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter logic [WIDTH-1:0] MAX = CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             jump
);
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [WIDTH-1:0] prev_next;

    assign prev_next = prev + 1'b1;
    assign wrap = prev_valid && prev == MAX && count == '0;
    // a held value is not a jump; prev_next wraps, so max->0 is excluded too
    assign jump = prev_valid && count != prev && count != prev_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev       <= count;
            prev_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/count_compare_pwm.sv
// count_compare_pwm: PWM against a double-buffered compare value, with wrap/match/jump
// flags, a saturating wrap tally and a sticky interrupt.
module count_compare_pwm
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int WRAP_CNT_W = 16,
    parameter logic [WIDTH-1:0] CMP_RESET = CNT_CMP_RESET
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count,
    input  logic                  en,
    input  logic [WIDTH-1:0]      cmp_wdata,
    input  logic                  cmp_we,
    input  logic                  irq_clr,
    output logic                  pwm_out,
    output logic                  match_pulse,
    output logic                  wrap_pulse,
    output logic                  jump_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]      cmp_active,
    output logic                  irq
);
    logic [WIDTH-1:0] shadow;
    logic             wrap;
    logic             jump;
    logic             match;

    count_edge_detect #(.WIDTH(WIDTH), .MAX({WIDTH{1'b1}})) u_edge (
        .clk  (clk),
        .rst  (rst),
        .count(count),
        .wrap (wrap),
        .jump (jump)
    );

    assign match = en && count == cmp_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out     <= 1'b0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            jump_pulse  <= 1'b0;
            wrap_cnt    <= '0;
            shadow      <= CMP_RESET;
            cmp_active  <= CMP_RESET;
            irq         <= 1'b0;
        end else begin
            pwm_out     <= en && count < cmp_active;
            match_pulse <= match;
            wrap_pulse  <= wrap;
            jump_pulse  <= jump;
            if (cmp_we)
                shadow <= cmp_wdata;
            // a write coinciding with a wrap lands in shadow for the following wrap
            if (wrap || !en)
                cmp_active <= shadow;
            if (wrap && wrap_cnt != '1)
                wrap_cnt <= wrap_cnt + 1'b1;
            irq <= wrap || match || (irq && !irq_clr);
        end
    end
endmodule

// File: doc/count_compare_pwm.md
Name: count_compare_pwm

Overview:
- Downstream consumer of the 8-bit up-counter with synchronous load. It samples the counter's count output every clock.
- Generates a PWM output against a double-buffered compare value.
- Flags compare matches, natural wraps (max to 0) and discontinuities such as loads or counter resets.
- Keeps a saturating wrap tally and a sticky interrupt for the surrounding control logic.

Parameters:
- WIDTH, 8, width of sampled count and compare registers
- WRAP_CNT_W, 16, width of the saturating wrap tally
- CMP_RESET, 8'h80, reset value of the shadow and active compare registers

Ports:
- clk  input  1  rising-edge clock, same clock as the upstream counter
- rst  input  1  asynchronous, active-low reset
- count  input  WIDTH  upstream counter value
- en  input  1  PWM/compare enable
- cmp_wdata  input  WIDTH  new compare value
- cmp_we  input  1  write strobe for the shadow compare register
- irq_clr  input  1  clears the sticky irq
- pwm_out  output  1  registered PWM output
- match_pulse  output  1  one-cycle pulse on count == active compare
- wrap_pulse  output  1  one-cycle pulse on natural wrap
- jump_pulse  output  1  one-cycle pulse on discontinuity
- wrap_cnt  output  WRAP_CNT_W  saturating count of natural wraps
- cmp_active  output  WIDTH  compare value currently in use
- irq  output  1  sticky flag, set by wrap or match

Behaviour:
- Reset (rst low, asynchronous):
  - pwm_out, match_pulse, wrap_pulse, jump_pulse, irq = 0
  - wrap_cnt = 0
  - shadow and cmp_active = CMP_RESET
  - prev register = 0; prev_valid = 0
- Sampling:
  - Each rising edge, prev <= count and prev_valid <= 1.
  - All outputs are registered. Latency is 1 cycle from the count value to its derived outputs.
- Shadow compare register:
  - cmp_we = 1 writes cmp_wdata into shadow at the clock edge.
- Active compare register (cmp_active):
  - Loaded from shadow when a wrap is detected (prev == 2^WIDTH-1 and count == 0, prev_valid = 1), or on any cycle with en = 0.
  - Same-cycle cmp_we with a wrap: cmp_active takes the old shadow, and the new value lands in shadow for the next wrap.
- pwm_out:
  - Equals en && (count < cmp_active), evaluated with the pre-update cmp_active.
  - cmp_active = 0 gives constant 0.
  - cmp_active = 2^WIDTH-1 is high for all counts except the maximum.
- match_pulse: en && (count == cmp_active).
- wrap_pulse: wrap condition above. Requires prev_valid; the first cycle after reset never flags.
- jump_pulse: prev_valid && count != prev && count != prev+1 (mod 2^WIDTH).
  - A held value (count == prev, e.g. upstream in reset) is not a jump.
  - Wrap is not a jump.
- wrap_cnt: increments on every wrap_pulse condition and saturates at all-ones, no roll-over.
- irq:
  - Set when the wrap or match condition is true.
  - Cleared by irq_clr.
  - Set wins over a simultaneous clear.
  - Stays high until cleared.
- en deasserted:
  - pwm_out and match_pulse forced 0 on the next edge.
  - Wrap/jump detection and wrap_cnt continue.
- Reset mid-operation: all state returns to reset values immediately. The first post-reset sample only primes prev.

Decomposition:
- Shared package (counter_pkg): WIDTH default, CMP_RESET default, and a localparam for max count (2^WIDTH-1).
- One natural sub-module: count_edge_detect. It holds prev/prev_valid and emits the raw wrap and jump conditions.
- The top level holds the compare double-buffer, PWM, wrap_cnt and irq.

Test Plan:
- Reset then free-run 0..255 with cmp_wdata = 8'h40 written before the first wrap:
  - First period uses 8'h80: pwm high for counts 0-127.
  - After wrap, cmp_active = 8'h40 and pwm is high for 64 cycles per period.
  - match_pulse fires once per period.
- Upstream load of 8'hBC at count 8'h11:
  - jump_pulse = 1 for exactly one cycle.
  - No wrap_pulse; wrap_cnt unchanged.
- Counter wraps 255 -> 0 three times: wrap_pulse three single-cycle pulses, wrap_cnt = 3, irq = 1.
- irq_clr asserted on the same cycle as a wrap: irq stays 1. irq_clr on a quiet cycle: irq = 0 next cycle.
- en = 0 with cmp_we = 8'h10:
  - pwm_out = 0 and match_pulse = 0.
  - cmp_active = 8'h10 one cycle after the write, without waiting for a wrap.
- Assert rst mid-period at count 8'h90:
  - All outputs are at reset values immediately.
  - The first post-reset sample produces no jump_pulse.
  - wrap_cnt forced to 16'hFFFF via 65535+ wraps (or forced preload) does not roll over.
